// File: rtl/sram_pkg.sv
// ============================================================================
// Module      : sram_pkg
// Description : Shared types and constants for the SRAM stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int SRAM_ADDR_W = 10;
    localparam int SRAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_W-1:0] sram_data_t;

endpackage

`default_nettype wire

// File: rtl/sram_rd_fifo.sv
// ============================================================================
// Module      : sram_rd_fifo
// Description : Small synchronous FIFO holding {last, data} read entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_rd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q;
    logic [c_PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = pop_i && !empty_o;
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= f_next(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= f_next(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_stream_reader.sv
// ============================================================================
// Module      : sram_stream_reader
// Description : Burst reader for the 1024x32 SRAM macro with a valid/ready
//               output stream and credit-based read issue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_stream_reader
    import sram_pkg::*;
#(
    parameter int ADDR_W    = SRAM_ADDR_W,
    parameter int DATA_W    = SRAM_DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_men,
    output logic              sram_ren,
    output logic              sram_wen,
    output logic [DATA_W-1:0] sram_bm,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int c_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int c_OCC_W = c_CNT_W + 1;
    localparam logic [ADDR_W:0] c_ONE = (ADDR_W + 1)'(1);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W:0]   issue_cnt_q;
    logic [ADDR_W:0]   out_cnt_q;
    logic              in_flight_q;
    logic              in_flight_last_q;

    logic [DATA_W:0]    w_fifo_rdata;
    logic [c_CNT_W-1:0] w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_accept;
    logic               w_issue;
    logic [c_OCC_W-1:0] w_occ;

    assign w_accept = (state_q == IDLE) && start;
    assign w_pop    = m_valid && m_ready;

    // Credit: words already buffered or in flight, minus the one leaving now.
    assign w_occ   = {1'b0, w_count} + c_OCC_W'(in_flight_q) - c_OCC_W'(w_pop);
    assign w_issue = (state_q == RUN) && (issue_cnt_q != '0)
                     && (w_occ < c_OCC_W'(BUF_DEPTH)) && !(w_full && !w_pop);

    sram_rd_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (DATA_W + 1),
        .CNT_W (c_CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_flight_q),
        .pop_i   (w_pop),
        .wdata_i ({in_flight_last_q, sram_dout}),
        .rdata_o (w_fifo_rdata),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_issue && (issue_cnt_q == c_ONE)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && (out_cnt_q == c_ONE)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q           <= '0;
            last_addr_q      <= '0;
            issue_cnt_q      <= '0;
            out_cnt_q        <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
        end else begin
            in_flight_q      <= w_issue;
            in_flight_last_q <= w_issue && (issue_cnt_q == c_ONE);
            if (w_accept) begin
                addr_q      <= base_addr;
                issue_cnt_q <= length;
                out_cnt_q   <= length;
            end else begin
                if (w_issue) begin
                    addr_q      <= addr_q + ADDR_W'(1);
                    last_addr_q <= addr_q;
                    issue_cnt_q <= issue_cnt_q - c_ONE;
                end
                if (w_pop) begin
                    out_cnt_q <= out_cnt_q - c_ONE;
                end
            end
        end
    end

    assign sram_ren  = w_issue;
    assign sram_men  = w_issue;
    assign sram_addr = w_issue ? addr_q : last_addr_q;
    assign sram_wen  = 1'b0;
    assign sram_bm   = '1;
    assign sram_din  = '0;

    assign m_valid = !w_empty;
    assign m_data  = w_fifo_rdata[DATA_W-1:0];
    assign m_last  = m_valid && w_fifo_rdata[DATA_W];

endmodule

`default_nettype wire
